// File: rtl/i2c_e2prom_slave.sv
`default_nettype none
// ============================================================================
// Module   : i2c_e2prom_slave
// Purpose  : I2C responder modelling a 24Cxx-style E2PROM. Decodes START/STOP,
//            the device address, one or two word-address bytes, then serves
//            sequential writes into, or sequential reads from, a byte memory.
// Options  : define I2C_E2PROM_SLAVE_WP_EN to add the write-protect input wp.
//            MEM_AW is expected to be 16 or less.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_e2prom_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'b1010000,
  parameter int         ADDR16     = 1,
  parameter int         MEM_AW     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl,
  input  logic              sda_in,
`ifdef I2C_E2PROM_SLAVE_WP_EN
  input  logic              wp,
`endif
  output logic              sda_oe,
  output logic              busy,
  output logic              wr_strobe,
  output logic [MEM_AW-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_DEV     = 4'd1;
  localparam logic [3:0] S_DEV_ACK = 4'd2;
  localparam logic [3:0] S_AHI     = 4'd3;
  localparam logic [3:0] S_AHI_ACK = 4'd4;
  localparam logic [3:0] S_ALO     = 4'd5;
  localparam logic [3:0] S_ALO_ACK = 4'd6;
  localparam logic [3:0] S_WR      = 4'd7;
  localparam logic [3:0] S_WR_ACK  = 4'd8;
  localparam logic [3:0] S_RD      = 4'd9;
  localparam logic [3:0] S_RD_ACK  = 4'd10;

  // Synchronizers plus one history stage for edge detection
  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;

  logic [3:0]        state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              rw_q, rw_d;
  logic              ack_rise_q, ack_rise_d;  // ninth SCL rise of the current ack slot seen
  logic [MEM_AW-1:0] ptr_q, ptr_d;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q, busy_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [MEM_AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              mem_we;

  logic [7:0] mem [0:(1<<MEM_AW)-1];

  logic       scl_rise, scl_fall, bus_start, bus_stop, last_bit, dev_match, wp_on;
  logic [7:0] rx_byte, rd_byte;

`ifdef I2C_E2PROM_SLAVE_WP_EN
  logic wp_s1_q, wp_s2_q;

  // Bring the write-protect level into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_s1_q <= 1'b0;
      wp_s2_q <= 1'b0;
    end else begin
      wp_s1_q <= wp;
      wp_s2_q <= wp_s1_q;
    end
  end
  assign wp_on = wp_s2_q;
`else
  assign wp_on = 1'b0;
`endif

  // Bus events are taken from the synchronized copies only
  assign scl_rise  = scl_s2_q & ~scl_h_q;
  assign scl_fall  = ~scl_s2_q & scl_h_q;
  assign bus_start = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign bus_stop  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
  assign rx_byte   = {shift_q[6:0], sda_s2_q};
  assign last_bit  = (bit_cnt_q == 3'd7);
  assign dev_match = (rx_byte[7:1] == SLAVE_ADDR);
  assign rd_byte   = mem[ptr_q];

  // State and datapath registers; sync stages reset to the idle (released) bus level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1_q    <= 1'b1;
      scl_s2_q    <= 1'b1;
      scl_h_q     <= 1'b1;
      sda_s1_q    <= 1'b1;
      sda_s2_q    <= 1'b1;
      sda_h_q     <= 1'b1;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      rw_q        <= 1'b0;
      ack_rise_q  <= 1'b0;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'd0;
    end else begin
      scl_s1_q    <= scl;
      scl_s2_q    <= scl_s1_q;
      scl_h_q     <= scl_s2_q;
      sda_s1_q    <= sda_in;
      sda_s2_q    <= sda_s1_q;
      sda_h_q     <= sda_s2_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      ack_rise_q  <= ack_rise_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Byte memory; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr_q] <= rx_byte;
  end

  // Next-state: bytes end on the eighth SCL rise, ack slots end on the ninth SCL fall
  always_comb begin
    state_d = state_q;
    if (bus_stop) begin
      state_d = S_IDLE;
    end else if (bus_start) begin
      state_d = S_DEV;
    end else begin
      case (state_q)
        S_DEV:     if (scl_rise && last_bit) state_d = dev_match ? S_DEV_ACK : S_IDLE;
        S_AHI:     if (scl_rise && last_bit) state_d = S_AHI_ACK;
        S_ALO:     if (scl_rise && last_bit) state_d = S_ALO_ACK;
        S_WR:      if (scl_rise && last_bit) state_d = S_WR_ACK;
        S_RD:      if (scl_rise && last_bit) state_d = S_RD_ACK;
        S_DEV_ACK: if (scl_fall && ack_rise_q)
                     state_d = rw_q ? S_RD : ((ADDR16 != 0) ? S_AHI : S_ALO);
        S_AHI_ACK: if (scl_fall && ack_rise_q) state_d = S_ALO;
        S_ALO_ACK: if (scl_fall && ack_rise_q) state_d = S_WR;
        S_WR_ACK:  if (scl_fall && ack_rise_q) state_d = S_WR;
        S_RD_ACK: begin
          if (scl_rise && sda_s2_q)          state_d = S_IDLE;
          else if (scl_fall && ack_rise_q)   state_d = S_RD;
        end
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Outputs and datapath: shift, pointer, ack/data drive, write commit
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    ack_rise_d  = ack_rise_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    mem_we      = 1'b0;
    if (bus_stop || bus_start) begin
      // Any partial byte is dropped; ptr survives for the random-read path
      bit_cnt_d  = 3'd0;
      ack_rise_d = 1'b0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
    end else begin
      case (state_q)
        S_DEV, S_AHI, S_ALO, S_WR: begin
          if (scl_rise) begin
            shift_d    = rx_byte;
            bit_cnt_d  = bit_cnt_q + 3'd1;
            ack_rise_d = 1'b0;
            if (last_bit) begin
              case (state_q)
                S_DEV: if (dev_match) begin
                  rw_d   = rx_byte[0];
                  busy_d = 1'b1;
                end
                S_AHI: for (int i = 8; i < MEM_AW && i < 16; i++) ptr_d[i] = rx_byte[3'(i-8)];
                S_ALO: for (int i = 0; i < MEM_AW && i < 8; i++)  ptr_d[i] = rx_byte[3'(i)];
                default: begin
                  if (!wp_on) begin
                    mem_we      = 1'b1;
                    wr_strobe_d = 1'b1;
                    wr_addr_d   = ptr_q;
                    wr_data_d   = rx_byte;
                  end
                  ptr_d = ptr_q + 1'b1;
                end
              endcase
            end
          end
        end
        S_DEV_ACK, S_AHI_ACK, S_ALO_ACK, S_WR_ACK: begin
          if (scl_rise) ack_rise_d = 1'b1;
          if (scl_fall) begin
            if (!ack_rise_q) begin
              sda_oe_d = (state_q == S_WR_ACK) ? ~wp_on : 1'b1;
            end else begin
              ack_rise_d = 1'b0;
              sda_oe_d   = 1'b0;
              if (state_q == S_DEV_ACK && rw_q) begin
                shift_d  = rd_byte;
                sda_oe_d = ~rd_byte[7];
              end
            end
          end
        end
        S_RD: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) ptr_d = ptr_q + 1'b1;
          end
          if (scl_fall) sda_oe_d = ~shift_q[7];
        end
        S_RD_ACK: begin
          if (scl_rise && !sda_s2_q) ack_rise_d = 1'b1;
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            if (ack_rise_q) begin
              ack_rise_d = 1'b0;
              bit_cnt_d  = 3'd0;
              shift_d    = rd_byte;
              sda_oe_d   = ~rd_byte[7];
            end
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_e2prom_slave.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_i2c_e2prom_slave
// Purpose  : Bit-banged I2C master driving i2c_e2prom_slave over an
//            open-drain SDA, checked against an array model of the E2PROM.
//            Define I2C_E2PROM_SLAVE_WP_EN to exercise write protect.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_e2prom_slave;

  localparam int         Q      = 10;        // quarter SCL period in clk cycles
  localparam logic [6:0] DEV    = 7'h50;
  localparam int         MEM_AW = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       m_oe = 1'b0;
  logic       sda_line;
  logic       sda_oe, busy, wr_strobe;
  logic [7:0] wr_addr, wr_data;
`ifdef I2C_E2PROM_SLAVE_WP_EN
  logic       wp = 1'b0;
`endif

  assign sda_line = ~(m_oe | sda_oe);

  always #10 clk = ~clk;

  i2c_e2prom_slave #(.SLAVE_ADDR(DEV), .ADDR16(1), .MEM_AW(MEM_AW)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl       (scl_m),
    .sda_in    (sda_line),
`ifdef I2C_E2PROM_SLAVE_WP_EN
    .wp        (wp),
`endif
    .sda_oe    (sda_oe),
    .busy      (busy),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  model_mem [256];
  bit          model_val [256];
  logic [7:0]  model_ptr = 8'd0;
  logic [15:0] exp_q [$];
  logic [15:0] obs_q [$];
  logic [7:0]  buf_d [8];
  logic        mon_en = 1'b0;
  logic        seen_oe = 1'b0;
  logic        seen_busy = 1'b0;

  // Record every committed byte and watch outputs during the mismatch window
  always @(negedge clk) begin
    if (wr_strobe) obs_q.push_back({wr_addr, wr_data});
    if (mon_en && sda_oe) seen_oe <= 1'b1;
    if (mon_en && busy)   seen_busy <= 1'b1;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    wait_clk(Q); m_oe = 1'b0; wait_clk(Q); scl_m = 1'b1;
    wait_clk(Q); m_oe = 1'b1; wait_clk(Q); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(Q); m_oe = 1'b1; wait_clk(Q); scl_m = 1'b1;
    wait_clk(Q); m_oe = 1'b0; wait_clk(2*Q);
  endtask

  task automatic send_bit(input logic b);
    wait_clk(Q); m_oe = ~b; wait_clk(Q); scl_m = 1'b1; wait_clk(2*Q); scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    wait_clk(Q); m_oe = 1'b0; wait_clk(Q); scl_m = 1'b1;
    wait_clk(Q); ack = ~sda_line; wait_clk(Q); scl_m = 1'b0;
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      wait_clk(Q); m_oe = 1'b0; wait_clk(Q); scl_m = 1'b1;
      wait_clk(Q); b[i] = sda_line; wait_clk(Q); scl_m = 1'b0;
    end
    wait_clk(Q); m_oe = master_ack; wait_clk(Q); scl_m = 1'b1; wait_clk(2*Q); scl_m = 1'b0;
  endtask

  // START, write-direction device byte and two word-address bytes
  task automatic addr_phase(input logic [15:0] a);
    logic ack;
    i2c_start();
    write_byte({DEV, 1'b0}, ack); chk_eq("dev_ack", 32'(ack), 32'd1);
    write_byte(a[15:8], ack);     chk_eq("ahi_ack", 32'(ack), 32'd1);
    write_byte(a[7:0], ack);      chk_eq("alo_ack", 32'(ack), 32'd1);
    model_ptr = a[7:0];
  endtask

  task automatic check_strobes();
    chk_eq("strobe_cnt", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk_eq("strobe_addr_data", 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic write_burst(input logic [15:0] a, input int n);
    logic ack;
    addr_phase(a);
    for (int i = 0; i < n; i++) begin
      write_byte(buf_d[i], ack);
      chk_eq("data_ack", 32'(ack), 32'd1);
      model_mem[model_ptr] = buf_d[i];
      model_val[model_ptr] = 1'b1;
      exp_q.push_back({model_ptr, buf_d[i]});
      model_ptr = model_ptr + 8'd1;
    end
    chk_eq("busy_in_xfer", 32'(busy), 32'd1);
    i2c_stop();
    chk_eq("busy_after_stop", 32'(busy), 32'd0);
    check_strobes();
  endtask

  task automatic read_burst(input logic [15:0] a, input int n, input bit set_addr);
    logic       ack;
    logic [7:0] b;
    if (set_addr) addr_phase(a);
    i2c_start();
    write_byte({DEV, 1'b1}, ack); chk_eq("rd_dev_ack", 32'(ack), 32'd1);
    for (int i = 0; i < n; i++) begin
      read_byte(i < n-1, b);
      chk_eq("rd_data", 32'(b), 32'(model_mem[model_ptr]));
      model_ptr = model_ptr + 8'd1;
    end
    i2c_stop();
    chk_eq("rd_sda_released", 32'(sda_oe), 32'd0);
    chk_eq("rd_busy_after_stop", 32'(busy), 32'd0);
  endtask

  task automatic mismatch(input logic [6:0] dev);
    logic ack;
    seen_oe = 1'b0; seen_busy = 1'b0;
    mon_en = 1'b1;
    i2c_start();
    write_byte({dev, 1'b0}, ack);
    chk_eq("mismatch_ack", 32'(ack), 32'd0);
    i2c_stop();
    mon_en = 1'b0;
    wait_clk(2);
    chk_eq("mismatch_sda_oe", 32'(seen_oe), 32'd0);
    chk_eq("mismatch_busy", 32'(seen_busy), 32'd0);
  endtask

  initial begin
    logic [15:0] a;
    int          n;
    logic [6:0]  d;
    // Reset values
    wait_clk(5);
    chk_eq("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    chk_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk_eq("rst_wr_data", 32'(wr_data), 32'd0);
    rst_n = 1'b1;
    wait_clk(5);

    // Single write then random read of the same byte
    buf_d[0] = 8'h5A;
    write_burst(16'h0012, 1);
    read_burst(16'h0012, 1, 1'b1);

    // Sequential write/read across the top of memory
    buf_d[0] = 8'h11; buf_d[1] = 8'h22; buf_d[2] = 8'h33;
    write_burst(16'h00FE, 3);
    read_burst(16'h00FE, 3, 1'b1);

    // Foreign device addresses
    mismatch(7'h51);
    do d = 7'($urandom); while (d == DEV);
    mismatch(d);

    // STOP after four data bits: nothing committed, then a clean transfer
    addr_phase(16'h0040);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    i2c_stop();
    chk_eq("abort_no_strobe", 32'(obs_q.size()), 32'd0);
    chk_eq("abort_sda_oe", 32'(sda_oe), 32'd0);
    chk_eq("abort_busy", 32'(busy), 32'd0);
    buf_d[0] = 8'h3C;
    write_burst(16'h0040, 1);
    read_burst(16'h0040, 1, 1'b1);

    // Reset in the middle of a data byte
    addr_phase(16'h0080);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    rst_n = 1'b0;
    wait_clk(3);
    chk_eq("midrst_sda_oe", 32'(sda_oe), 32'd0);
    chk_eq("midrst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    model_ptr = 8'd0;
    i2c_stop();
    chk_eq("midrst_no_strobe", 32'(obs_q.size()), 32'd0);
    buf_d[0] = 8'hC3; buf_d[1] = 8'h96;
    write_burst(16'h0080, 2);
    read_burst(16'h0080, 2, 1'b1);

    // Randomized bursts, address high byte is beyond MEM_AW and must be ignored
    for (int t = 0; t < 8; t++) begin
      a = 16'($urandom);
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) buf_d[i] = 8'($urandom);
      write_burst(a, n);
      read_burst(a, n, 1'b1);
      if (model_val[model_ptr]) read_burst(16'h0000, 1, 1'b0);
    end

`ifdef I2C_E2PROM_SLAVE_WP_EN
    begin
      logic ack;
      buf_d[0] = 8'h99;
      write_burst(16'h0005, 1);
      wp = 1'b1;
      wait_clk(4);
      addr_phase(16'h0005);
      write_byte(8'h77, ack);
      chk_eq("wp_data_nack", 32'(ack), 32'd0);
      model_ptr = model_ptr + 8'd1;
      i2c_stop();
      chk_eq("wp_no_strobe", 32'(obs_q.size()), 32'd0);
      wp = 1'b0;
      read_burst(16'h0005, 1, 1'b1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard bound on run time
  initial begin
    #20ms;
    $display("FAIL timeout: got no completion, expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
